// File: rtl/pea_ctrl.sv
// pea_ctrl: loop sequencer for the 3x3 PE array (weights, ifmap rows, psum strobes)
module pea_ctrl #(
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned PE_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 cfg_stride,
  input  logic [CNT_WIDTH-1:0] cfg_oh,
  input  logic [CNT_WIDTH-1:0] cfg_ic,
  input  logic [CNT_WIDTH-1:0] cfg_oc,
  input  logic                 wgt_vld,
  input  logic                 ifm_vld,
  output logic                 busy,
  output logic                 done,
  output logic                 stride,
  output logic                 wgt_read,
  output logic                 ifm_read,
  output logic                 pvalid,
  output logic                 ic_done,
  output logic                 oc_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_WGT  = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int unsigned DRN_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PE_LAT - 1);

  logic [2:0]           r_state;
  logic [2:0]           w_next_state;
  logic                 r_stride;
  logic [CNT_WIDTH-1:0] r_oh_max;
  logic [CNT_WIDTH-1:0] r_ic_max;
  logic [CNT_WIDTH-1:0] r_oc_max;
  logic [CNT_WIDTH-1:0] r_row_cnt;
  logic [CNT_WIDTH-1:0] r_ic_cnt;
  logic [CNT_WIDTH-1:0] r_oc_cnt;
  logic [1:0]           r_beat_cnt;
  logic [DRN_W-1:0]     r_drain_cnt;
  logic [PE_LAT-1:0]    r_win_dl;
  logic [PE_LAT-1:0]    r_last_dl;
  logic [PE_LAT-1:0]    r_ocl_dl;

  logic       w_wgt_read;
  logic       w_ifm_read;
  logic       w_win;
  logic       w_last;
  logic       w_ocl;
  logic [1:0] w_beat_last;
  logic       w_drain_end;
  logic       w_ic_wrap;
  logic       w_oc_wrap;

  // Zero-length loop config is treated as a single iteration
  function automatic logic [CNT_WIDTH-1:0] f_max(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - CNT_WIDTH'(1);
  endfunction

  // Row 0 fills the 3-row window; later rows slide by the stride
  assign w_beat_last = (r_row_cnt == '0) ? 2'd2 : (r_stride ? 2'd1 : 2'd0);
  assign w_drain_end = (r_drain_cnt == DRN_LAST);
  assign w_ic_wrap   = (r_ic_cnt == r_ic_max);
  assign w_oc_wrap   = (r_oc_cnt == r_oc_max);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and beat strobes
  always_comb begin
    w_next_state = r_state;
    w_wgt_read   = 1'b0;
    w_ifm_read   = 1'b0;
    w_win        = 1'b0;
    w_last       = 1'b0;
    w_ocl        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_LD_WGT;
      end
      S_LD_WGT: begin
        w_wgt_read = wgt_vld;
        if (wgt_vld && (r_beat_cnt == 2'd2)) w_next_state = S_COMPUTE;
      end
      S_COMPUTE: begin
        w_ifm_read = ifm_vld;
        if (ifm_vld && (r_beat_cnt == w_beat_last)) begin
          w_win = 1'b1;
          if (r_row_cnt == r_oh_max) begin
            w_last       = 1'b1;
            w_ocl        = w_ic_wrap;
            w_next_state = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_drain_end) w_next_state = (w_ic_wrap && w_oc_wrap) ? S_DONE : S_LD_WGT;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Config latch and loop counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stride    <= 1'b0;
      r_oh_max    <= '0;
      r_ic_max    <= '0;
      r_oc_max    <= '0;
      r_row_cnt   <= '0;
      r_ic_cnt    <= '0;
      r_oc_cnt    <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_stride    <= cfg_stride;
            r_oh_max    <= f_max(cfg_oh);
            r_ic_max    <= f_max(cfg_ic);
            r_oc_max    <= f_max(cfg_oc);
            r_row_cnt   <= '0;
            r_ic_cnt    <= '0;
            r_oc_cnt    <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
          end
        end
        S_LD_WGT: begin
          if (wgt_vld) begin
            if (r_beat_cnt == 2'd2) begin
              r_beat_cnt <= '0;
              r_row_cnt  <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + 2'd1;
            end
          end
        end
        S_COMPUTE: begin
          r_drain_cnt <= '0;
          if (ifm_vld) begin
            if (r_beat_cnt == w_beat_last) begin
              r_beat_cnt <= '0;
              r_row_cnt  <= r_row_cnt + CNT_WIDTH'(1);
            end else begin
              r_beat_cnt <= r_beat_cnt + 2'd1;
            end
          end
        end
        S_DRAIN: begin
          if (w_drain_end) begin
            r_drain_cnt <= '0;
            if (w_ic_wrap) begin
              r_ic_cnt <= '0;
              if (!w_oc_wrap) r_oc_cnt <= r_oc_cnt + CNT_WIDTH'(1);
            end else begin
              r_ic_cnt <= r_ic_cnt + CNT_WIDTH'(1);
            end
          end else begin
            r_drain_cnt <= r_drain_cnt + DRN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // PE latency delay line; free-running so stalls never delay queued strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_win_dl  <= '0;
      r_last_dl <= '0;
      r_ocl_dl  <= '0;
    end else begin
      r_win_dl  <= (r_win_dl << 1)  | PE_LAT'(w_win);
      r_last_dl <= (r_last_dl << 1) | PE_LAT'(w_last);
      r_ocl_dl  <= (r_ocl_dl << 1)  | PE_LAT'(w_ocl);
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign stride   = r_stride;
  assign wgt_read = w_wgt_read;
  assign ifm_read = w_ifm_read;
  assign pvalid   = r_win_dl[PE_LAT-1];
  assign ic_done  = r_last_dl[PE_LAT-1];
  assign oc_done  = r_ocl_dl[PE_LAT-1];

endmodule

// File: doc/pea_ctrl.md
Name: pea_ctrl

Overview:
- Sequencer for the 3x3 PE array datapath: ROW x COL pe_3x3 grid, rf_wgt/rf_ifm shift buffers and rf_psum accumulators.
- Generates `wgt_read`, `ifm_read`, `pvalid`, `ic_done`, `oc_done` and `stride` for one layer tile.
- Loops over output channels (outer), input channels (inner) and output rows, stalling on buffer-side data availability.
- Sits between the layer-level scheduler (start/done) and the PE array.

Parameters:
- CNT_WIDTH, 8, width of the oh/ic/oc config fields and loop counters.
- PE_LAT, 2, cycles from the ifm_read beat that completes a 3-row window to valid pe psum; must be >= 1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse; ignored while busy
- cfg_stride  in  1  0 = stride 1, 1 = stride 2; latched at start
- cfg_oh  in  CNT_WIDTH  output rows per pass; latched; 0 treated as 1
- cfg_ic  in  CNT_WIDTH  input-channel passes per oc; latched; 0 treated as 1
- cfg_oc  in  CNT_WIDTH  output channels; latched; 0 treated as 1
- wgt_vld  in  1  weight buffer has a beat available
- ifm_vld  in  1  ifmap buffer has a beat available
- busy  out  1  high from the cycle after start acceptance through DONE
- done  out  1  one-cycle pulse in DONE
- stride  out  1  latched cfg_stride
- wgt_read  out  1  weight shift beat
- ifm_read  out  1  ifmap row shift beat
- pvalid  out  1  psum valid to rf_psum
- ic_done  out  1  last psum of an input-channel pass
- oc_done  out  1  last psum of the last ic pass of an output channel

Behaviour:
- Reset: state IDLE. All outputs 0. All counters and the delay line cleared. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE -> LD_WGT -> COMPUTE -> DRAIN -> (LD_WGT | DONE) -> IDLE.
- IDLE:
  - start=1 latches config and clears ic_cnt, oc_cnt and row_cnt.
  - Next state is LD_WGT; busy goes high the next cycle.
- LD_WGT:
  - wgt_read = wgt_vld.
  - beat_cnt counts accepted beats.
  - After 3 beats -> COMPUTE, with beat_cnt and row_cnt cleared.
- COMPUTE:
  - ifm_read = ifm_vld; only accepted beats advance counters.
  - Output row 0 needs 3 beats; every later row needs 1 beat (stride 1) or 2 beats (stride 2).
  - The beat completing a row raises win_pulse and increments row_cnt.
  - The beat completing row cfg_oh-1 also raises last_pulse -> DRAIN.
- Delay line:
  - win_pulse and last_pulse go through a PE_LAT-deep shift register.
  - The register shifts every cycle regardless of stalls.
  - pvalid = delayed win_pulse.
  - ic_done = delayed last_pulse.
  - oc_done = delayed last_pulse AND (ic_cnt == cfg_ic-1), using the ic_cnt value captured at the beat.
- DRAIN:
  - Waits PE_LAT cycles so the final pvalid/ic_done/oc_done emerge.
  - Then advances ic_cnt; on ic wrap it clears ic_cnt and advances oc_cnt.
  - If the oc wraps -> DONE, else -> LD_WGT.
  - wgt_read and ifm_read are 0 throughout.
- DONE: done=1 for one cycle, then IDLE.
- Stalls: vld low holds the state and counters. Outputs already in the delay line still emerge on schedule.
- Boundaries:
  - start while busy is ignored.
  - cfg_oh=1 gives exactly 3 beats and 1 pvalid per pass.
  - Counters compare against cfg-1; no wrap-around beyond CNT_WIDTH.
- Totals per layer:
  - Weight beats: 3·oc·ic.
  - Ifm beats: oc·ic·(3 + (oh-1)·(stride+1)).
  - pvalid pulses: oc·ic·oh.

Test Plan:
- Basic timing: oh=4, stride=0, ic=1, oc=1, vld=1, start at T.
  - wgt_read at T+1..T+3; ifm_read at T+4..T+9.
  - pvalid at T+8..T+11; ic_done=oc_done=1 at T+11 only.
  - done at T+12; busy low at T+13.
- Stride 2: oh=3, stride=1, ic=1, oc=1.
  - Exactly 7 ifm_read beats.
  - pvalid 3 times, PE_LAT after the 3rd, 5th and 7th beat.
  - stride output = 1.
- Channel loops: oh=2, ic=3, oc=2.
  - 18 wgt_read, 24 ifm_read, 12 pvalid.
  - 6 ic_done pulses; oc_done only on the 3rd and 6th ic_done.
  - Single done pulse.
- Stalls: oh=4, stride=0, ic=1, oc=1, ifm_vld low every other cycle and wgt_vld low for the first 2 cycles.
  - Beat counts unchanged (3 wgt, 6 ifm); each pvalid lands exactly PE_LAT after its completing beat.
  - No ifm_read/wgt_read while vld is low.
- Reset mid-COMPUTE: assert rstn=0 during the 2nd ifm beat.
  - All outputs 0 immediately; IDLE; no done.
  - The next start runs a full, correct pass.
- start while busy and zero config:
  - A second start pulse mid-run is ignored (same counts as a single run).
  - cfg_oh=cfg_ic=cfg_oc=0 behaves as 1/1/1 (3 wgt, 3 ifm, 1 pvalid).
